// File: rtl/swc_multi.sv
// rtl/swc_multi.sv - multi-channel stopwatch counter with a shared tick prescaler
// Commands from the sequencer instruction port act on the selected channel only.
module swc_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 24,
  parameter int PRESCALE = 1,
  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [11:0]         inst,
  input  logic                inst_en,
  output logic [WIDTH-1:0]    counter,
  output logic [CHANNELS-1:0] ready,
  output logic                ready_any,
  output logic [CH_BITS-1:0]  sel
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [3:0] OP_SEL  = 4'd1;
  localparam logic [3:0] OP_LDB  = 4'd2;
  localparam logic [3:0] OP_CLR  = 4'd3;
  localparam logic [3:0] OP_UP   = 4'd4;
  localparam logic [3:0] OP_DN   = 4'd5;
  localparam logic [3:0] OP_STOP = 4'd6;
  localparam logic [3:0] OP_GO   = 4'd7;
  localparam logic [3:0] OP_MODE = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN_UP, S_RUN_DN, S_PAUSE_UP, S_PAUSE_DN, S_DONE
  } state_t;

  logic [PW-1:0]       presc_q, presc_d;
  logic [CH_BITS-1:0]  sel_q;
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    preset_q [CHANNELS];
  state_t              state_q  [CHANNELS];
  logic [CHANNELS-1:0] auto_q, ready_q;

  logic [3:0]       op;
  logic [7:0]       imm;
  logic             tick;
  logic             cmd_valid;
  logic [WIDTH-1:0] preset_d;

  assign op        = inst[11:8];
  assign imm       = inst[7:0];
  assign tick      = (presc_q == PW'(PRESCALE - 1));
  assign presc_d   = tick ? '0 : presc_q + PW'(1);
  // Only opcodes that touch channel state claim the channel and mask its tick.
  assign cmd_valid = inst_en && (op >= OP_LDB) && (op <= OP_MODE);
  assign preset_d  = (preset_q[sel_q] << 8) | WIDTH'(imm);

  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_q <= '0;
      sel_q   <= '0;
      auto_q  <= '0;
      ready_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= '0;
        preset_q[i] <= '0;
        state_q[i]  <= S_IDLE;
      end
    end else begin
      presc_q <= presc_d;
      if (inst_en && (op == OP_SEL) && (int'(imm) < CHANNELS)) sel_q <= imm[CH_BITS-1:0];
      for (int i = 0; i < CHANNELS; i++) begin
        if (cmd_valid && (sel_q == CH_BITS'(i))) begin
          case (op)
            OP_LDB:  preset_q[i] <= preset_d;
            OP_CLR:  begin count_q[i] <= '0; ready_q[i] <= 1'b0; state_q[i] <= S_IDLE; end
            OP_UP:   begin count_q[i] <= '0; ready_q[i] <= 1'b0; state_q[i] <= S_RUN_UP; end
            OP_DN:   begin count_q[i] <= preset_q[i]; ready_q[i] <= 1'b0; state_q[i] <= S_RUN_DN; end
            OP_STOP: begin
              if (state_q[i] == S_RUN_UP)      state_q[i] <= S_PAUSE_UP;
              else if (state_q[i] == S_RUN_DN) state_q[i] <= S_PAUSE_DN;
            end
            OP_GO:   begin
              if (state_q[i] == S_PAUSE_UP)      state_q[i] <= S_RUN_UP;
              else if (state_q[i] == S_PAUSE_DN) state_q[i] <= S_RUN_DN;
            end
            OP_MODE: auto_q[i] <= imm[0];
            default: ;
          endcase
        end else if (tick) begin
          if (state_q[i] == S_RUN_UP) begin
            if (count_q[i] == preset_q[i]) begin
              ready_q[i] <= 1'b1;
              if (auto_q[i]) count_q[i] <= '0;
              else           state_q[i] <= S_DONE;
            end else begin
              count_q[i] <= count_q[i] + WIDTH'(1);
            end
          end else if (state_q[i] == S_RUN_DN) begin
            if (count_q[i] == '0) begin
              ready_q[i] <= 1'b1;
              if (auto_q[i]) count_q[i] <= preset_q[i];
              else           state_q[i] <= S_DONE;
            end else begin
              count_q[i] <= count_q[i] - WIDTH'(1);
            end
          end
        end
      end
    end
  end

  assign counter   = count_q[sel_q];
  assign ready     = ready_q;
  assign ready_any = |ready_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_swc_multi.sv
// tb/tb_swc_multi.sv - checks swc_multi (PRESCALE 1 and 4 side by side) against a reference model
module tb_swc_multi;
  localparam int CH = 4;
  localparam int W  = 24;
  localparam int unsigned MASK = 32'h00FF_FFFF;

  logic          clock = 1'b0;
  logic          reset;
  logic          inst_en;
  logic [11:0]   inst;
  logic [W-1:0]  cnt_a, cnt_b;
  logic [CH-1:0] rdy_a, rdy_b;
  logic          any_a, any_b;
  logic [1:0]    sel_a, sel_b;

  swc_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(1)) u_p1 (
    .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en),
    .counter(cnt_a), .ready(rdy_a), .ready_any(any_a), .sel(sel_a)
  );
  swc_multi #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(4)) u_p4 (
    .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en),
    .counter(cnt_b), .ready(rdy_b), .ready_any(any_b), .sel(sel_b)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 idle, 1 counting up, 2 counting down, 3 finished
  int          presc [2] = '{1, 4};
  int unsigned m_cnt [2][CH];
  int unsigned m_pre [2][CH];
  bit          m_auto[2][CH];
  bit          m_rdy [2][CH];
  bit          m_pause[2][CH];
  int          m_mode[2][CH];
  int          m_sel [2];
  int          m_pc  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit rst, input bit en, input logic [11:0] in);
    bit tick;
    int op, imm;
    op  = int'(in[11:8]);
    imm = int'(in[7:0]);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_sel[k] = 0;
        m_pc[k]  = 0;
        for (int c = 0; c < CH; c++) begin
          m_cnt[k][c] = 0; m_pre[k][c] = 0; m_auto[k][c] = 0;
          m_rdy[k][c] = 0; m_pause[k][c] = 0; m_mode[k][c] = 0;
        end
      end else begin
        tick = (m_pc[k] == presc[k] - 1);
        m_pc[k] = tick ? 0 : m_pc[k] + 1;
        for (int c = 0; c < CH; c++) begin
          if (en && op >= 2 && op <= 8 && c == m_sel[k]) begin
            case (op)
              2: m_pre[k][c] = ((m_pre[k][c] << 8) | imm) & MASK;
              3: begin m_cnt[k][c] = 0; m_rdy[k][c] = 0; m_mode[k][c] = 0; m_pause[k][c] = 0; end
              4: begin m_cnt[k][c] = 0; m_rdy[k][c] = 0; m_mode[k][c] = 1; m_pause[k][c] = 0; end
              5: begin m_cnt[k][c] = m_pre[k][c]; m_rdy[k][c] = 0; m_mode[k][c] = 2; m_pause[k][c] = 0; end
              6: if (m_mode[k][c] == 1 || m_mode[k][c] == 2) m_pause[k][c] = 1;
              7: if (m_mode[k][c] == 1 || m_mode[k][c] == 2) m_pause[k][c] = 0;
              default: m_auto[k][c] = imm[0];
            endcase
          end else if (tick && !m_pause[k][c] && m_mode[k][c] == 1) begin
            if (m_cnt[k][c] == m_pre[k][c]) begin
              m_rdy[k][c] = 1;
              if (m_auto[k][c]) m_cnt[k][c] = 0;
              else              m_mode[k][c] = 3;
            end else begin
              m_cnt[k][c] = (m_cnt[k][c] + 1) & MASK;
            end
          end else if (tick && !m_pause[k][c] && m_mode[k][c] == 2) begin
            if (m_cnt[k][c] == 0) begin
              m_rdy[k][c] = 1;
              if (m_auto[k][c]) m_cnt[k][c] = m_pre[k][c];
              else              m_mode[k][c] = 3;
            end else begin
              m_cnt[k][c] = m_cnt[k][c] - 1;
            end
          end
        end
        if (en && op == 1 && imm < CH) m_sel[k] = imm;
      end
    end
  endfunction

  task automatic compare_all();
    logic [CH-1:0] er;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < CH; c++) er[c] = m_rdy[k][c];
      chk($sformatf("model_counter[%0d]", k), (k == 0) ? cnt_a : cnt_b, m_cnt[k][m_sel[k]]);
      chk($sformatf("model_ready[%0d]", k), (k == 0) ? rdy_a : rdy_b, er);
      chk($sformatf("model_ready_any[%0d]", k), (k == 0) ? any_a : any_b, |er);
      chk($sformatf("model_sel[%0d]", k), (k == 0) ? sel_a : sel_b, m_sel[k]);
    end
  endtask

  task automatic cyc(input bit rst, input bit en, input logic [11:0] in);
    reset   = rst;
    inst_en = en;
    inst    = in;
    model_step(rst, en, in);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic op(input logic [11:0] in);
    cyc(1'b1, 1'b1, in);
  endtask

  initial begin
    int dn_seq[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    int lat;
    bit got;
    reset = 1'b0; inst_en = 1'b1; inst = 12'h4AB;

    cyc(1'b0, 1'b1, 12'h4AB);
    cyc(1'b0, 1'b1, 12'h4AB);
    chk("rst_counter", cnt_a, 0);
    chk("rst_ready", rdy_a, 0);
    chk("rst_sel", sel_a, 0);
    chk("rst_ready_p4", rdy_b, 0);

    op(12'h200); op(12'h200); op(12'h205); op(12'h400);
    chk("up_start", cnt_a, 0);
    for (int k = 1; k <= 5; k++) begin
      op(12'h000);
      chk("up_count", cnt_a, k);
      chk("up_ready_low", rdy_a[0], 0);
    end
    op(12'h000);
    chk("up_ready_high", rdy_a[0], 1);
    chk("up_hold", cnt_a, 5);
    chk("up_ready_any", any_a, 1);
    op(12'h000);
    chk("up_hold_done", cnt_a, 5);

    op(12'h102); op(12'h203); op(12'h801); op(12'h500);
    chk("dn_start", cnt_a, 3);
    for (int i = 0; i < 8; i++) begin
      op(12'h000);
      chk("dn_count", cnt_a, dn_seq[i]);
      chk("dn_ready_sticky", rdy_a[2], (i >= 3));
    end
    op(12'h300);
    chk("clr_counter", cnt_a, 0);
    chk("clr_ready", rdy_a[2], 0);

    op(12'h101); op(12'h20A); op(12'h400);
    for (int k = 0; k < 4; k++) op(12'h000);
    chk("stop_pre", cnt_a, 4);
    op(12'h600);
    for (int k = 0; k < 20; k++) begin
      op(12'h000);
      chk("stop_hold", cnt_a, 4);
    end
    op(12'h700);
    chk("go_edge", cnt_a, 4);
    for (int k = 5; k <= 10; k++) begin
      op(12'h000);
      chk("go_count", cnt_a, k);
      chk("go_ready_low", rdy_a[1], 0);
    end
    op(12'h000);
    chk("go_ready_high", rdy_a[1], 1);
    chk("go_hold", cnt_a, 10);

    op(12'h100); op(12'h200); op(12'h200); op(12'h264); op(12'h400);
    op(12'h101); op(12'h200); op(12'h200); op(12'h202); op(12'h500);
    chk("indep_dn_start", cnt_a, 2);
    op(12'h000); op(12'h000);
    chk("indep_dn_zero", cnt_a, 0);
    chk("indep_dn_not_ready", rdy_a[1], 0);
    op(12'h000);
    chk("indep_dn_ready", rdy_a[1], 1);
    op(12'h1FF);
    chk("sel_oob_ff", sel_a, 1);
    op(12'h104);
    chk("sel_oob_4", sel_a, 1);
    op(12'h100);
    chk("indep_ch0_running", cnt_a, 11);

    cyc(1'b1, 1'b0, 12'h300);
    cyc(1'b1, 1'b0, 12'h400);
    cyc(1'b1, 1'b0, 12'h101);
    chk("inst_en_low_sel", sel_a, 0);
    chk("inst_en_low_count", cnt_a, 14);
    chk("inst_en_low_ready1", rdy_a[1], 1);

    for (int n = 0; n < 400; n++) begin
      logic [3:0] opc;
      logic [7:0] im;
      opc = 4'($urandom_range(0, 15));
      im  = 8'($urandom);
      if (opc == 4'd1) im = 8'($urandom_range(0, 5));
      if (opc == 4'd2) im = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'd0;
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, {opc, im});
    end

    op(12'h103); op(12'h200); op(12'h200); op(12'h202); op(12'h800); op(12'h400);
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      op(12'h000);
      if (rdy_b[3] === 1'b1) begin
        lat = i;
        got = 1'b1;
      end
    end
    chk("p4_ready_seen", got, 1);
    chk("p4_latency_window", (lat >= 9 && lat <= 15), 1);
    chk("p4_hold", cnt_b, 2);
    chk("p1_ready3", rdy_a[3], 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
